// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and parameter defaults.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W_DEF     = 5;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the EX-stage load and the ID-stage sources.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  mem_read_en_ex,
  input  logic [REG_ADDR_W-1:0] dest_ex,
  input  logic [REG_ADDR_W-1:0] src1_id,
  input  logic [REG_ADDR_W-1:0] src2_id,
  input  logic                  two_src_id,
  output logic                  load_use
);

  logic w_dest_nz;
  logic w_src1_hit;
  logic w_src2_hit;

  // Register 0 is hard-wired, so a load targeting it can never create a hazard
  always_comb begin
    w_dest_nz  = (dest_ex != '0);
    w_src1_hit = (dest_ex == src1_id);
    w_src2_hit = two_src_id && (dest_ex == src2_id);
    load_use   = mem_read_en_ex && w_dest_nz && (w_src1_hit || w_src2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait FSM with timeout,
// load-use stall and taken-branch flush, merged by priority.
// Optional build macro PIPE_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W     = REG_ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TO_CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_en_mem,
  input  logic                  mem_write_en_mem,
  input  logic                  dmem_ack,
  input  logic                  mem_read_en_ex,
  input  logic [REG_ADDR_W-1:0] dest_ex,
  input  logic [REG_ADDR_W-1:0] src1_id,
  input  logic [REG_ADDR_W-1:0] src2_id,
  input  logic                  two_src_id,
  input  logic                  branch_taken,
  output logic                  dmem_req,
  output logic                  pc_hold,
  output logic                  if2id_hold,
  output logic                  if2id_flush,
  output logic                  id2ex_hold,
  output logic                  id2ex_bubble,
  output logic                  ex2mem_hold,
  output logic                  mem2wb_bubble,
  output logic                  timeout_err
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic [TO_CNT_W-1:0] w_to_cnt_nxt;
  logic                r_timeout_err;
  logic                w_mem_op;
  logic                w_load_use;
  logic                w_freeze;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .mem_read_en_ex (mem_read_en_ex),
    .dest_ex        (dest_ex),
    .src1_id        (src1_id),
    .src2_id        (src2_id),
    .two_src_id     (two_src_id),
    .load_use       (w_load_use)
  );

  assign w_mem_op = mem_read_en_mem | mem_write_en_mem;

  // State, timeout counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
      if (w_state_nxt == ST_ERR) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Next state: enter WAIT on an unacknowledged access, leave on ack or timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_to_cnt_nxt = r_to_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op && !dmem_ack) begin
          w_state_nxt  = ST_WAIT;
          w_to_cnt_nxt = TO_CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt  = ST_IDLE;
          w_to_cnt_nxt = '0;
        end else if (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES)) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_CNT_W'(1);
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_to_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs: freeze beats load-use beats branch flush; everything quiet during reset
  always_comb begin
    dmem_req      = 1'b0;
    pc_hold       = 1'b0;
    if2id_hold    = 1'b0;
    if2id_flush   = 1'b0;
    id2ex_hold    = 1'b0;
    id2ex_bubble  = 1'b0;
    ex2mem_hold   = 1'b0;
    mem2wb_bubble = 1'b0;
    timeout_err   = 1'b0;
    w_freeze      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        dmem_req = w_mem_op;
        w_freeze = w_mem_op && !dmem_ack;
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        w_freeze = !dmem_ack;
      end
      ST_ERR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_freeze = 1'b0;
      end
    endcase
    if (!rst) begin
      timeout_err = r_timeout_err;
      if (w_freeze) begin
        pc_hold       = 1'b1;
        if2id_hold    = 1'b1;
        id2ex_hold    = 1'b1;
        ex2mem_hold   = 1'b1;
        mem2wb_bubble = 1'b1;
      end else if (w_load_use) begin
        pc_hold      = 1'b1;
        if2id_hold   = 1'b1;
        id2ex_bubble = 1'b1;
      end else if (branch_taken) begin
        if2id_flush  = 1'b1;
        id2ex_bubble = 1'b1;
      end
    end else begin
      dmem_req = 1'b0;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (pc_hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
